// File: rtl/instr_register_pkg.sv
// Shared types for the instruction register and its controller.
// address_t width fixes the register depth (2**$bits(address_t) entries).
package instr_register_pkg;

    typedef logic [4:0]  address_t;
    typedef logic [15:0] operand_t;

    typedef enum logic [3:0] {
        ZERO,
        PASSA,
        PASSB,
        ADD,
        SUB,
        MULT,
        DIV,
        MOD
    } opcode_t;

    typedef struct packed {
        opcode_t  opcode;
        operand_t operand_a;
        operand_t operand_b;
    } instruction_t;

    typedef enum logic [1:0] {
        INIT,
        IDLE,
        RUN,
        DRAIN
    } ctrl_state_t;

endpackage

// File: rtl/instr_reg_ctrl_if.sv
// Producer and consumer handshakes of the instruction register controller.
// master = the surrounding system, slave = the controller.
interface instr_reg_ctrl_if;
    import instr_register_pkg::*;

    logic         req0_valid;
    logic         req0_ready;
    opcode_t      req0_opcode;
    operand_t     req0_operand_a;
    operand_t     req0_operand_b;

    logic         req1_valid;
    logic         req1_ready;
    opcode_t      req1_opcode;
    operand_t     req1_operand_a;
    operand_t     req1_operand_b;

    logic         rd_valid;
    logic         rd_ready;
    instruction_t rd_instruction;

    modport master (
        output req0_valid, req0_opcode, req0_operand_a, req0_operand_b,
        input  req0_ready,
        output req1_valid, req1_opcode, req1_operand_a, req1_operand_b,
        input  req1_ready,
        input  rd_valid, rd_instruction,
        output rd_ready
    );

    modport slave (
        input  req0_valid, req0_opcode, req0_operand_a, req0_operand_b,
        output req0_ready,
        input  req1_valid, req1_opcode, req1_operand_a, req1_operand_b,
        output req1_ready,
        output rd_valid, rd_instruction,
        input  rd_ready
    );

endinterface

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter; a tie goes to the requester not granted last.
// The priority flag only moves when the caller reports an accepted grant.
module rr_arb2 (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] valid,
    input  logic       update,
    output logic [1:0] grant
);

    logic last;  // index of the most recently accepted requester

    always_comb begin
        // NOTE: default every always_comb output first so no path leaves it unassigned (latch).
        grant = 2'b00;
        if (valid[0] && (!valid[1] || last)) begin
            grant[0] = 1'b1;
        end else if (valid[1]) begin
            grant[1] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
            last <= 1'b1;
        end else if (update) begin
            last <= grant[1];
        end
    end

endmodule

// File: rtl/instr_reg_ctrl.sv
// Instruction register controller: scrubs every entry after reset, then writes
// round-robin-arbitrated producer instructions and presents them in order to one consumer.
module instr_reg_ctrl
    import instr_register_pkg::*;
#(
    parameter int DEPTH = 32,  // must equal 2**$bits(address_t)
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              enable,
    instr_reg_ctrl_if.slave   bus,
    output logic [CNT_W-1:0]  count,
    output logic              busy,
    output logic              load_en,
    output opcode_t           opcode,
    output operand_t          operand_a,
    output operand_t          operand_b,
    output address_t          write_pointer,
    output address_t          read_pointer,
    input  instruction_t      instruction_word
);

    localparam int ADDR_W = $bits(address_t);

    ctrl_state_t  state;
    logic [CNT_W-1:0] init_cnt;
    address_t     wr_head;
    address_t     rd_head;
    logic [1:0]   req_valid;
    logic [1:0]   grant;
    logic         room;
    logic         accept;
    logic         pop;
    instruction_t acc_data;

    assign req_valid = {bus.req1_valid, bus.req0_valid};

    rr_arb2 u_arb (
        .clk     (clk),
        .reset_n (reset_n),
        .valid   (req_valid),
        .update  (accept),
        .grant   (grant)
    );

    assign room           = (count < CNT_W'(DEPTH));
    assign bus.req0_ready = (state == RUN) && room && grant[0];
    assign bus.req1_ready = (state == RUN) && room && grant[1];
    assign accept         = (bus.req0_valid && bus.req0_ready) ||
                            (bus.req1_valid && bus.req1_ready);
    assign acc_data       = grant[1]
                          ? '{bus.req1_opcode, bus.req1_operand_a, bus.req1_operand_b}
                          : '{bus.req0_opcode, bus.req0_operand_a, bus.req0_operand_b};

    // An accepted entry is counted at once but is not readable until its load edge has passed.
    assign bus.rd_valid       = ((state == RUN) || (state == DRAIN)) &&
                                (count > CNT_W'(load_en));
    assign bus.rd_instruction = instruction_word;
    assign pop                = bus.rd_valid && bus.rd_ready;

    assign busy         = (state == INIT) || (state == DRAIN);
    assign read_pointer = rd_head;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= INIT;
            init_cnt      <= '0;
            wr_head       <= '0;
            rd_head       <= '0;
            count         <= '0;
            load_en       <= 1'b0;
            opcode        <= ZERO;
            operand_a     <= '0;
            operand_b     <= '0;
            write_pointer <= '0;
        end else begin
            load_en <= 1'b0;

            case (state)
                INIT: begin
                    if (init_cnt < CNT_W'(DEPTH)) begin
                        load_en       <= 1'b1;
                        opcode        <= ZERO;
                        operand_a     <= '0;
                        operand_b     <= '0;
                        write_pointer <= init_cnt[ADDR_W-1:0];
                        init_cnt      <= init_cnt + CNT_W'(1);
                    end else begin
                        write_pointer <= '0;
                        wr_head       <= '0;
                        rd_head       <= '0;
                        state         <= enable ? RUN : IDLE;
                    end
                end
                IDLE:    if (enable)        state <= RUN;
                RUN:     if (!enable)       state <= DRAIN;
                DRAIN:   if (count == '0)   state <= IDLE;
                default:                    state <= INIT;
            endcase

            // Accepts only happen in RUN, so this never collides with the scrub writes.
            if (accept) begin
                load_en       <= 1'b1;
                opcode        <= acc_data.opcode;
                operand_a     <= acc_data.operand_a;
                operand_b     <= acc_data.operand_b;
                write_pointer <= wr_head;
                wr_head       <= wr_head + 1'b1;
            end

            if (pop) begin
                rd_head <= rd_head + 1'b1;
            end

            if (accept && !pop) begin
                count <= count + CNT_W'(1);
            end else if (pop && !accept) begin
                count <= count - CNT_W'(1);
            end
        end
    end

endmodule
